// File: rtl/instr_fetch.sv
// Instruction-fetch front end: drives the instruction SRAM, which has a 1-cycle read latency,
// and hands {pc, instr} to decode through a 2-entry valid/ready buffer.
module instr_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        instr_sram_en,
  output logic        instr_sram_we,
  output logic [31:0] instr_sram_addr,
  output logic [31:0] instr_sram_wdata,
  input  logic [31:0] instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        fetch_fault,
  output logic [31:0] fault_pc
);

  localparam logic [1:0] S_BOOT  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FAULT = 2'd2;

  if (BUF_DEPTH != 2) begin : g_bad_depth
    $error("instr_fetch only supports BUF_DEPTH == 2");
  end

  logic [1:0]  state;
  logic [31:0] pc;
  logic        inflight;
  logic [31:0] inflight_pc;
  logic [31:0] buf_pc    [2];
  logic [31:0] buf_instr [2];
  logic        head;
  logic [1:0]  count;
  logic [31:0] fault_pc_q;

  logic        redirect;
  logic        redirect_ok;
  logic        pop;
  logic        credit_ok;
  logic        issue_seq;
  logic        issue;
  logic        write;
  logic        wr_idx;

  // Redirect is gated by rst_n so the SRAM port sits at its reset values while reset is held.
  // A same-cycle pop frees a slot, which is what sustains one fetch per cycle.
  always_comb begin
    redirect    = redirect_valid & rst_n;
    redirect_ok = redirect & (redirect_pc[1:0] == 2'b00);
    pop         = (count != 2'd0) & if_ready & ~redirect;
    credit_ok   = (({1'b0, count} + {2'b00, inflight}) < 3'd2) | pop;
    issue_seq   = rst_n & ~redirect &
                  ((state == S_BOOT) | ((state == S_RUN) & credit_ok));
    issue       = redirect_ok | issue_seq;
    write       = inflight & ~redirect;
    wr_idx      = head ^ count[0];
  end

  assign instr_sram_en    = issue;
  assign instr_sram_we    = 1'b0;
  assign instr_sram_wdata = 32'h0000_0000;
  assign instr_sram_addr  = redirect_ok ? redirect_pc : pc;

  assign if_valid    = (count != 2'd0);
  assign if_pc       = buf_pc[head];
  assign if_instr    = buf_instr[head];
  assign fetch_fault = (state == S_FAULT);
  assign fault_pc    = fault_pc_q;

  // Redirects flush the buffer and kill the response returning this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_BOOT;
      pc           <= RESET_PC;
      inflight     <= 1'b0;
      inflight_pc  <= 32'h0000_0000;
      buf_pc[0]    <= 32'h0000_0000;
      buf_pc[1]    <= 32'h0000_0000;
      buf_instr[0] <= 32'h0000_0000;
      buf_instr[1] <= 32'h0000_0000;
      head         <= 1'b0;
      count        <= 2'd0;
      fault_pc_q   <= 32'h0000_0000;
    end else if (redirect) begin
      head        <= 1'b0;
      count       <= 2'd0;
      inflight    <= redirect_ok;
      inflight_pc <= redirect_pc;
      if (redirect_ok) begin
        pc    <= redirect_pc + 32'd4;
        state <= S_RUN;
      end else begin
        fault_pc_q <= redirect_pc;
        state      <= S_FAULT;
      end
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= pc;
        pc          <= pc + 32'd4;
        if (state == S_BOOT) begin
          state <= S_RUN;
        end
      end
      if (write) begin
        buf_pc[wr_idx]    <= inflight_pc;
        buf_instr[wr_idx] <= instr;
      end
      head  <= head ^ pop;
      count <= count + {1'b0, write} - {1'b0, pop};
    end
  end

endmodule
